// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the 5-stage pipeline. It owns HI/LO, computes the result
// at launch, holds busy for a fixed latency, then writes HI/LO together.
//
// state  | meaning
// S_IDLE | no operation in flight; MTHI/MTLO write directly, MULT/DIV launch
// S_BUSY | result parked in res_hi/res_lo, counting down to the HI/LO write
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             commit_q, commit_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic               div_by_zero;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag;
    logic [31:0]        dvd, dvs;
    logic [31:0]        uq, ur;
    logic [31:0]        quot, rem;

    // One shared unsigned divider; signed DIV runs on magnitudes and fixes signs afterwards,
    // which also yields 0x80000000 / -1 = 0x80000000 without a special case.
    always_comb begin
        prod_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u      = {32'd0, a} * {32'd0, b};
        div_signed  = (op == OP_DIV);
        div_by_zero = (b == 32'd0);
        a_neg       = div_signed & a[31];
        b_neg       = div_signed & b[31];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        dvd         = a_mag;
        dvs         = div_by_zero ? 32'd1 : b_mag;
        uq          = dvd / dvs;
        ur          = dvd % dvs;
        quot        = (a_neg ^ b_neg) ? -uq : uq;
        rem         = a_neg ? -ur : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        commit_d = commit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            commit_d = 1'b1;
                            cnt_d    = MULT_LOAD;
                            state_d  = S_BUSY;
                        end
                        OP_MULTU: begin
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                            commit_d = 1'b1;
                            cnt_d    = MULT_LOAD;
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still takes the full latency but leaves HI/LO alone.
                            res_hi_d = rem;
                            res_lo_d = quot;
                            commit_d = ~div_by_zero;
                            cnt_d    = DIV_LOAD;
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    if (commit_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
